// File: rtl/mod_exp_engine_if.sv
// mod_exp_engine_if: start/operand/result bundle for the modular
// exponentiation engine.
interface mod_exp_engine_if #(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
);
  logic             in_rdy;
  logic [WIDTH-1:0] base;
  logic [EXP_W-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             out_rdy;
  logic             err;

  modport master (
    output in_rdy, base, exponent, modulus,
    input  busy, out, out_rdy, err
  );

  modport slave (
    input  in_rdy, base, exponent, modulus,
    output busy, out, out_rdy, err
  );
endinterface

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: base^exponent mod modulus via right-to-left square-and-
// multiply on a bit-serial modmul. MODEXP_CYCLE_COUNT_EN adds cycles[31:0].
module mod_exp_engine #(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MODEXP_CYCLE_COUNT_EN
  output logic [31:0]        cycles,
`endif
  mod_exp_engine_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    CHECK,
    MUL,
    SQR,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] out_r;
  logic [EXP_W-1:0] e_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m_x;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   t1;
  logic [WIDTH:0]   t2;
  logic [WIDTH:0]   t3;
  logic [CW-1:0]    cnt;
  logic             mm_last;
  logic             start;
  logic             busy_r;
  logic             rdy_r;
  logic             err_r;

  assign start   = (state == IDLE) && bus.in_rdy;
  assign mm_last = (cnt == CW'(WIDTH - 1));

  // One interleaved step: double, reduce, conditionally add b, reduce.
  always_comb begin
    m_x = {1'b0, m_r};
    dbl = acc << 1;
    t1  = (dbl >= m_x) ? dbl - m_x : dbl;
    t2  = t1 + (mm_a[WIDTH-1] ? {1'b0, mm_b} : '0);
    t3  = (t2 >= m_x) ? t2 - m_x : t2;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.in_rdy) begin
          state_n = (bus.modulus == '0) ? DONE : REDUCE;
        end
      end
      REDUCE: begin
        if (mm_last) state_n = CHECK;
      end
      CHECK: begin
        if (e_r == '0) state_n = DONE;
        else if (e_r[0]) state_n = MUL;
        else state_n = SQR;
      end
      MUL: begin
        if (mm_last) begin
          state_n = ((e_r >> 1) == '0) ? DONE : SQR;
        end
      end
      SQR: begin
        if (mm_last) state_n = CHECK;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_r    <= '0;
      b_r    <= '0;
      r_r    <= '0;
      e_r    <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      out_r  <= '0;
      busy_r <= 1'b0;
      rdy_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            m_r    <= bus.modulus;
            e_r    <= bus.exponent;
            mm_a   <= bus.base;
            mm_b   <= WIDTH'(1);
            acc    <= '0;
            cnt    <= '0;
            r_r    <= '0;
            b_r    <= '0;
            busy_r <= 1'b1;
            err_r  <= 1'b0;
          end
        end
        REDUCE, MUL, SQR: begin
          acc  <= t3;
          mm_a <= mm_a << 1;
          cnt  <= cnt + 1'b1;
          if (mm_last) begin
            acc <= '0;
            cnt <= '0;
            if (state == REDUCE) begin
              b_r <= t3[WIDTH-1:0];
              r_r <= (m_r == WIDTH'(1)) ? '0 : WIDTH'(1);
            end
            if (state == MUL) begin
              r_r  <= t3[WIDTH-1:0];
              mm_a <= b_r;
              mm_b <= b_r;
            end
            if (state == SQR) begin
              b_r <= t3[WIDTH-1:0];
              e_r <= e_r >> 1;
            end
          end
        end
        CHECK: begin
          mm_a <= e_r[0] ? r_r : b_r;
          mm_b <= b_r;
        end
        DONE: begin
          out_r  <= (m_r == '0) ? '0 : r_r;
          err_r  <= (m_r == '0);
          rdy_r  <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.out     = out_r;
  assign bus.out_rdy = rdy_r;
  assign bus.err     = err_r;

`ifdef MODEXP_CYCLE_COUNT_EN
  logic [31:0] cyc_r;

  always_ff @(posedge clk) begin
    if (!reset) cyc_r <= '0;
    else if (start) cyc_r <= '0;
    else if (busy_r) cyc_r <= cyc_r + 32'd1;
  end

  assign cycles = cyc_r;
`endif

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: directed and random operations checked against a
// plain-arithmetic modular exponentiation model.
module tb_mod_exp_engine;
  localparam int W  = 16;
  localparam int EW = 16;

  typedef struct {
    logic [W-1:0] out;
    logic         err;
    int           lat;
    int           start;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   quiet = 1'b0;
  exp_t q[$];

  mod_exp_engine_if #(.WIDTH(W), .EXP_W(EW)) bus ();

`ifdef MODEXP_CYCLE_COUNT_EN
  logic [31:0] cycles;
`endif

  mod_exp_engine #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MODEXP_CYCLE_COUNT_EN
    .cycles (cycles),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] b,
                                         input logic [EW-1:0] e,
                                         input logic [W-1:0] m);
    longint unsigned r;
    longint unsigned bb;
    longint unsigned mm;
    if (m == '0) return '0;
    mm = longint'(m);
    r  = 1 % mm;
    bb = longint'(b) % mm;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return W'(r);
  endfunction

  // Edges from the start edge (counted as 1) to the edge raising out_rdy.
  function automatic int lat_model(input logic [EW-1:0] e, input logic [W-1:0] m);
    int k;
    int n1;
    k  = 0;
    n1 = 0;
    if (m == '0) return 2;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        k = i + 1;
        n1++;
      end
    end
    if (k == 0) return 3 + W;
    return 2 + W + k + n1 * W + (k - 1) * W;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (reset) begin
      if (bus.out_rdy) begin
        if (q.size() == 0) begin
          check("stray_out_rdy", 1, 0);
        end else begin
          x = q.pop_front();
          check("out", bus.out, x.out);
          check("err", bus.err, x.err);
          check("latency", edge_cnt - x.start + 1, x.lat);
          check("busy_at_done", bus.busy, 0);
`ifdef MODEXP_CYCLE_COUNT_EN
          check("cycles", cycles, x.lat - 1);
`endif
        end
      end else if (!quiet) begin
        check("busy", bus.busy,
              (q.size() == 0) ? 0 : ((edge_cnt >= q[0].start) ? 1 : 0));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input bit track);
    exp_t x;
    @(posedge clk);
    #1;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    bus.in_rdy   = 1'b1;
    if (track) begin
      x.out   = model(b, e, m);
      x.err   = (m == '0);
      x.lat   = lat_model(e, m);
      x.start = edge_cnt + 1;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.in_rdy   = 1'b0;
    bus.base     = W'($urandom);
    bus.exponent = EW'($urandom);
    bus.modulus  = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] m);
    start_op(b, e, m, 1'b1);
    wait_done(2000);
  endtask

  int dv[10][3] = '{
    '{4, 13, 497},
    '{300, 3, 7},
    '{300, 3, 1},
    '{7, 0, 13},
    '{0, 5, 13},
    '{0, 0, 13},
    '{9, 4, 0},
    '{4, 13, 497},
    '{65535, 65535, 65535},
    '{12345, 65535, 65521}
  };

  initial begin
    logic [W-1:0]  rb;
    logic [W-1:0]  rm;
    logic [EW-1:0] re;
    int            nb;

    reset        = 1'b0;
    bus.in_rdy   = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", bus.out, 0);
    check("rst_out_rdy", bus.out_rdy, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
`ifdef MODEXP_CYCLE_COUNT_EN
    check("rst_cycles", cycles, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    check("model_445", model(16'd4, 16'd13, 16'd497), 445);
    check("model_6", model(16'd300, 16'd3, 16'd7), 6);
    check("model_24", model(16'd2, 16'd10, 16'd1000), 24);
    check("model_exp0", model(16'd7, 16'd0, 16'd13), 1);
    check("lat_exp0", lat_model(16'd0, 16'd13), 3 + W);

    for (int i = 0; i < 10; i++) begin
      do_op(W'(dv[i][0]), EW'(dv[i][1]), W'(dv[i][2]));
      if (i == 0) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("out_held", bus.out, 445);
      end
    end

    quiet = 1'b1;
    start_op(16'd3, 16'd5, 16'd101, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_out", bus.out, 0);
    check("abort_out_rdy", bus.out_rdy, 0);
    quiet = 1'b0;

    start_op(16'd2, 16'd10, 16'd1000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.base     = 16'd5;
    bus.exponent = 16'd3;
    bus.modulus  = 16'd11;
    bus.in_rdy   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_rdy = 1'b0;
    wait_done(2000);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 60; i++) begin
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rm = '0;
        1: rm = W'(1);
        2: rm = W'($urandom_range(2, 20));
        default: rm = W'($urandom);
      endcase
      nb = $urandom_range(0, EW);
      re = EW'($urandom) & EW'((32'h1 << nb) - 32'h1);
      do_op(rb, re, rm);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
